// File: rtl/dpd_out_round_sat.sv
// dpd_out_round_sat
//   Output stage after the complex 8-term adder of the DPD actuator.
//   Shifts each widened component right by 0..3 with round-half-up, saturates
//   it back to DWIDTH bits, and counts saturated samples for software.
//   Three-stage pipeline, one sample per clock, valid-qualified, no backpressure.
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   din_valid    input sample strobe
//   din          {din_i, din_q}, each IWIDTH bits two's complement
//   shift        right-shift amount, captured with each valid sample
//   sat_cnt_clr  synchronous clear of sat_cnt / sat_flag (wins over an event)
//   dout_valid   output sample strobe
//   dout         {dout_i, dout_q}, each DWIDTH bits two's complement
//   sat_flag     sticky saturation indicator
//   sat_cnt      saturated-sample count, holds at all-ones
module dpd_out_round_sat #(
  parameter int DWIDTH     = 16,
  parameter int EXTRA_BITS = 3,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              din_valid,
  input  logic [2*(DWIDTH+EXTRA_BITS)-1:0]  din,
  input  logic [1:0]                        shift,
  input  logic                              sat_cnt_clr,
  output logic                              dout_valid,
  output logic [2*DWIDTH-1:0]               dout,
  output logic                              sat_flag,
  output logic [CNT_WIDTH-1:0]              sat_cnt
);

  localparam int IWIDTH = DWIDTH + EXTRA_BITS;
  // One extra bit so x + rc cannot wrap at the positive end.
  localparam int RWIDTH = IWIDTH + 1;

  // Round-half-up shift: add half an output LSB, then arithmetic shift.
  function automatic logic signed [RWIDTH-1:0] round_shift(
    input logic signed [IWIDTH-1:0] x,
    input logic [1:0]               s
  );
    logic signed [RWIDTH-1:0] xe;
    logic signed [RWIDTH-1:0] rc;
    xe = {x[IWIDTH-1], x};
    rc = '0;
    if (s != 2'd0) rc[s - 2'd1] = 1'b1;
    return (xe + rc) >>> s;
  endfunction

  // Returns {clamped, value}. In range iff all bits from the DWIDTH-1 sign
  // position upward agree.
  function automatic logic [DWIDTH:0] saturate(
    input logic signed [RWIDTH-1:0] r
  );
    logic [RWIDTH-DWIDTH:0] top;
    top = r[RWIDTH-1:DWIDTH-1];
    if ((top == '0) || (top == '1))
      return {1'b0, r[DWIDTH-1:0]};
    else if (r[RWIDTH-1])
      return {1'b1, 1'b1, {(DWIDTH-1){1'b0}}};
    else
      return {1'b1, 1'b0, {(DWIDTH-1){1'b1}}};
  endfunction

  logic                      v1, v2, v3;
  logic signed [IWIDTH-1:0]  x_i1, x_q1;
  logic [1:0]                s1;
  logic signed [RWIDTH-1:0]  r_i2, r_q2;
  logic                      e3;
  logic [DWIDTH:0]           sat_i_res, sat_q_res;

  assign sat_i_res  = saturate(r_i2);
  assign sat_q_res  = saturate(r_q2);
  assign dout_valid = v3;

  // Valid pipe always shifts; data stages load only on their incoming valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1   <= 1'b0;
      v2   <= 1'b0;
      v3   <= 1'b0;
      x_i1 <= '0;
      x_q1 <= '0;
      s1   <= '0;
      r_i2 <= '0;
      r_q2 <= '0;
      dout <= '0;
      e3   <= 1'b0;
    end else begin
      v1 <= din_valid;
      v2 <= v1;
      v3 <= v2;
      if (din_valid) begin
        x_i1 <= din[2*IWIDTH-1:IWIDTH];
        x_q1 <= din[IWIDTH-1:0];
        s1   <= shift;
      end
      if (v1) begin
        r_i2 <= round_shift(x_i1, s1);
        r_q2 <= round_shift(x_q1, s1);
      end
      if (v2) begin
        dout <= {sat_i_res[DWIDTH-1:0], sat_q_res[DWIDTH-1:0]};
        e3   <= sat_i_res[DWIDTH] | sat_q_res[DWIDTH];
      end
    end
  end

  // One count per sample regardless of how many components clamped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (sat_cnt_clr) begin
      sat_cnt  <= '0;
      sat_flag <= 1'b0;
    end else if (v3 && e3) begin
      sat_flag <= 1'b1;
      if (sat_cnt != '1) sat_cnt <= sat_cnt + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_dpd_out_round_sat.sv
module tb_dpd_out_round_sat;

  localparam int DW = 16;
  localparam int IW = 19;

  logic              clk;
  logic              rst_n;
  logic              din_valid;
  logic [2*IW-1:0]   din;
  logic [1:0]        shift;
  logic              sat_cnt_clr;
  logic              dout_valid;
  logic [2*DW-1:0]   dout;
  logic              sat_flag;
  logic [15:0]       sat_cnt;
  logic              dout_valid4;
  logic [2*DW-1:0]   dout4;
  logic              sat_flag4;
  logic [3:0]        sat_cnt4;

  dpd_out_round_sat dut (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .shift(shift),
    .sat_cnt_clr(sat_cnt_clr), .dout_valid(dout_valid), .dout(dout),
    .sat_flag(sat_flag), .sat_cnt(sat_cnt)
  );

  // Same stimulus, narrow counter to exercise the hold-at-all-ones behaviour.
  dpd_out_round_sat #(.CNT_WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .din_valid(din_valid), .din(din), .shift(shift),
    .sat_cnt_clr(sat_cnt_clr), .dout_valid(dout_valid4), .dout(dout4),
    .sat_flag(sat_flag4), .sat_cnt(sat_cnt4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int ei;
    int eq;
    int c;
  } exp_t;
  exp_t sbq[$];

  typedef struct {
    int di;
    int dq;
    int sh;
    int ei;
    int eq;
  } vec_t;

  task automatic check(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  function automatic int model(input int x, input int s);
    int t;
    t = x + ((s == 0) ? 0 : (1 << (s - 1)));
    t = t >>> s;
    if (t > 32767) t = 32767;
    if (t < -32768) t = -32768;
    return t;
  endfunction

  function automatic int out_i();
    logic signed [DW-1:0] v;
    v = dout[2*DW-1:DW];
    return int'(v);
  endfunction

  function automatic int out_q();
    logic signed [DW-1:0] v;
    v = dout[DW-1:0];
    return int'(v);
  endfunction

  // Drives one valid sample and leaves din_valid high; follow with idle() for a gap.
  task automatic send(input int di, input int dq, input int sh, input int ei, input int eq);
    logic [31:0] a;
    logic [31:0] b;
    exp_t e;
    a = di;
    b = dq;
    din_valid = 1'b1;
    din   = {a[IW-1:0], b[IW-1:0]};
    shift = sh[1:0];
    e.ei = ei;
    e.eq = eq;
    e.c  = cyc;
    sbq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && dout_valid) begin
      if (sbq.size() == 0) begin
        check("unexpected_dout_valid", 1, 0);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        check("dout_i", out_i(), e.ei);
        check("dout_q", out_q(), e.eq);
        check("latency", cyc - e.c, 3);
      end
    end
  end

  task automatic summary();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
  endtask

  initial begin
    #200000;
    check("timeout", 1, 0);
    summary();
    $finish;
  end

  vec_t tbl[12];
  int last_i, last_q;
  bit found;

  initial begin
    tbl[0]  = '{12, -12, 3, 2, -1};
    tbl[1]  = '{40000, -40000, 0, 32767, -32768};
    tbl[2]  = '{131068, 0, 2, 32767, 0};
    tbl[3]  = '{262143, -262144, 3, 32767, -32768};
    tbl[4]  = '{-12, 12, 3, -1, 2};
    tbl[5]  = '{3, -3, 1, 2, -1};
    tbl[6]  = '{6, -6, 2, 2, -1};
    tbl[7]  = '{5, -5, 0, 5, -5};
    tbl[8]  = '{-5, 5, 2, -1, 1};
    tbl[9]  = '{32767, -32768, 0, 32767, -32768};
    tbl[10] = '{262143, -262144, 0, 32767, -32768};
    tbl[11] = '{7, -7, 3, 1, -1};

    rst_n = 1'b0;
    din_valid = 1'b0;
    din = '0;
    shift = 2'd0;
    sat_cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    idle(1);

    check("rst_dout_valid", int'(dout_valid), 0);
    check("rst_dout", int'(dout), 0);
    check("rst_sat_cnt", int'(sat_cnt), 0);
    check("rst_sat_flag", int'(sat_flag), 0);

    // Table vectors back-to-back; three of them saturate.
    for (int k = 0; k < 12; k++)
      send(tbl[k].di, tbl[k].dq, tbl[k].sh, tbl[k].ei, tbl[k].eq);
    idle(6);
    check("tbl_sat_cnt", int'(sat_cnt), 3);
    check("tbl_sat_flag", int'(sat_flag), 1);
    check("tbl_sat_cnt4", int'(sat_cnt4), 3);

    // Streaming with shift toggling every sample.
    for (int k = 0; k < 8; k++) begin
      int di, dq, sh;
      di = 1000 * k - 3997 + k * k;
      dq = -(di * 5) + 13;
      sh = (k % 2 == 0) ? 0 : 3;
      last_i = model(di, sh);
      last_q = model(dq, sh);
      send(di, dq, sh, last_i, last_q);
    end
    idle(2);
    idle(4);
    check("hold_valid", int'(dout_valid), 0);
    check("hold_dout_i", out_i(), last_i);
    check("hold_dout_q", out_q(), last_q);
    check("stream_sat_cnt", int'(sat_cnt), 3);

    // Clear, then 20 saturating samples.
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1 sat_cnt_clr = 1'b0;
    check("clr_sat_cnt", int'(sat_cnt), 0);
    check("clr_sat_flag", int'(sat_flag), 0);
    for (int k = 0; k < 20; k++) send(40000, 0, 0, 32767, 0);
    idle(6);
    check("cnt20_sat_cnt", int'(sat_cnt), 20);
    check("cnt20_sat_cnt4", int'(sat_cnt4), 15);
    check("cnt20_sat_flag4", int'(sat_flag4), 1);

    // Clear coincident with a saturating sample's count edge: the event is lost.
    send(-40000, 0, 0, -32768, 0);
    idle(1);
    found = 1'b0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (dout_valid) found = 1'b1;
    end
    check("coinc_found", int'(found), 1);
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1 sat_cnt_clr = 1'b0;
    check("coinc_sat_cnt", int'(sat_cnt), 0);
    check("coinc_sat_flag", int'(sat_flag), 0);
    check("coinc_sat_cnt4", int'(sat_cnt4), 0);
    idle(3);
    check("coinc_after_cnt", int'(sat_cnt), 0);
    check("coinc_after_flag", int'(sat_flag), 0);

    // Get a nonzero count, then reset with two samples in flight.
    send(40000, 40000, 0, 32767, 32767);
    idle(6);
    check("pre_rst_sat_cnt", int'(sat_cnt), 1);
    send(50000, 1, 0, 32767, 1);
    send(2, 50000, 0, 2, 32767);
    din_valid = 1'b0;
    #2 rst_n = 1'b0;
    sbq.delete();
    #1;
    check("mid_rst_valid", int'(dout_valid), 0);
    check("mid_rst_dout", int'(dout), 0);
    check("mid_rst_sat_cnt", int'(sat_cnt), 0);
    check("mid_rst_sat_flag", int'(sat_flag), 0);
    @(negedge clk) rst_n = 1'b1;
    idle(1);
    send(8, 0, 1, 4, 0);
    idle(6);
    check("post_rst_sat_cnt", int'(sat_cnt), 0);
    check("sb_empty", sbq.size(), 0);

    summary();
    $finish;
  end

endmodule
